// File: rtl/hangman_pkg.sv
// Shared types and helpers for the hangman game controller.
package hangman_pkg;

  typedef enum logic [2:0] {SETUP, READY, SEND, PLAY, WIN, LOSE} state_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_if.sv
// Radio TX handshake between the game controller and the wireless transmitter.
interface hangman_game_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       msg_sent;

  modport master (output tx_valid, output tx_data, output msg_sent, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input msg_sent, output tx_ready);
endinterface

// File: rtl/hangman_letter_match.sv
// Compares one guess against every stored letter; hit when any position matches.
module hangman_letter_match #(
  parameter int WORD_LEN = 5
) (
  input  logic [8*WORD_LEN-1:0] i_word_flat,
  input  logic [7:0]            i_char,
  output logic [WORD_LEN-1:0]   o_match,
  output logic                  o_hit
);

  always_comb begin
    o_match = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      o_match[i] = (i_word_flat[8*i +: 8] == i_char);
    end
  end

  assign o_hit = |o_match;

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman sequencer: word entry, radio transfer of the word, guess scoring, win/lose.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN     = 5,
  parameter int MAX_MISTAKES = 6
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  role_switch,
  input  logic                  host_strb,
  input  logic [7:0]            host_char,
  input  logic                  host_word_submit,
  input  logic                  player_strb,
  input  logic [7:0]            player_char,
  input  logic                  restart,
  hangman_game_ctrl_if.master   tx,
  output logic [8*WORD_LEN-1:0] word_flat,
  output logic [WORD_LEN-1:0]   reveal_mask,
  output logic [3:0]            mistakes,
  output state_t                state,
  output logic                  red,
  output logic                  green,
  output logic                  blue,
  output logic                  error
);

  localparam int             IW         = $clog2(WORD_LEN + 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(WORD_LEN - 1);
  localparam logic [IW-1:0]  FULL_IDX   = IW'(WORD_LEN);
  localparam logic [3:0]     MISS_LIMIT = 4'(MAX_MISTAKES);

  state_t                r_state, w_nxt_state;
  logic [IW-1:0]         r_idx, w_nxt_idx;
  logic [7:0]            r_word [WORD_LEN];
  logic [7:0]            w_nxt_word [WORD_LEN];
  logic [WORD_LEN-1:0]   r_mask, w_nxt_mask;
  logic [3:0]            r_mistakes, w_nxt_mistakes;
  logic [25:0]           r_guessed, w_nxt_guessed;
  logic                  r_error, w_nxt_error;
  logic                  r_msg_sent, w_nxt_msg_sent;
  logic                  r_tx_valid, w_nxt_tx_valid;
  logic [7:0]            r_tx_data, w_nxt_tx_data;
  logic                  r_red, r_green, r_blue;

  logic                  w_host_strb, w_host_submit, w_player_strb;
  logic [7:0]            w_off;
  logic [25:0]           w_letter_bit;
  logic [WORD_LEN-1:0]   w_match;
  logic                  w_hit;

  assign w_host_strb   = host_strb & ~role_switch;
  assign w_host_submit = host_word_submit & ~role_switch;
  assign w_player_strb = player_strb & role_switch;
  assign w_off         = player_char - ASCII_A;
  assign w_letter_bit  = 26'(1) << w_off[4:0];

  always_comb begin
    word_flat = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      word_flat[8*i +: 8] = r_word[i];
    end
  end

  hangman_letter_match #(.WORD_LEN(WORD_LEN)) u_match (
    .i_word_flat (word_flat),
    .i_char      (player_char),
    .o_match     (w_match),
    .o_hit       (w_hit)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_word     = r_word;
    w_nxt_mask     = r_mask;
    w_nxt_mistakes = r_mistakes;
    w_nxt_guessed  = r_guessed;
    w_nxt_error    = 1'b0;
    w_nxt_msg_sent = 1'b0;
    w_nxt_tx_valid = r_tx_valid;
    w_nxt_tx_data  = r_tx_data;

    if (restart) begin
      w_nxt_state    = SETUP;
      w_nxt_idx      = '0;
      w_nxt_mask     = '0;
      w_nxt_mistakes = '0;
      w_nxt_guessed  = '0;
      w_nxt_tx_valid = 1'b0;
      w_nxt_tx_data  = '0;
      for (int unsigned i = 0; i < WORD_LEN; i++) w_nxt_word[i] = '0;
    end else begin
      case (r_state)
        SETUP: begin
          if (w_host_strb) begin
            if (is_letter(host_char)) begin
              for (int unsigned i = 0; i < WORD_LEN; i++) begin
                if (r_idx == IW'(i)) w_nxt_word[i] = host_char;
              end
              w_nxt_idx = r_idx + IW'(1);
              if (w_nxt_idx == FULL_IDX) w_nxt_state = READY;
            end else begin
              w_nxt_error = 1'b1;
            end
          end else if (w_host_submit) begin
            w_nxt_error = 1'b1;
          end
        end
        READY: begin
          if (w_host_strb) begin
            w_nxt_error = 1'b1;
          end else if (w_host_submit) begin
            w_nxt_state    = SEND;
            w_nxt_idx      = '0;
            w_nxt_tx_valid = 1'b1;
            w_nxt_tx_data  = r_word[0];
          end
        end
        SEND: begin
          // tx_data is reloaded only on an accepted byte, so it holds through stalls
          if (r_tx_valid && tx.tx_ready) begin
            if (r_idx == LAST_IDX) begin
              w_nxt_state    = PLAY;
              w_nxt_idx      = '0;
              w_nxt_tx_valid = 1'b0;
              w_nxt_msg_sent = 1'b1;
              w_nxt_mask     = '0;
              w_nxt_mistakes = '0;
              w_nxt_guessed  = '0;
            end else begin
              w_nxt_idx = r_idx + IW'(1);
              for (int unsigned i = 0; i < WORD_LEN; i++) begin
                if (w_nxt_idx == IW'(i)) w_nxt_tx_data = r_word[i];
              end
            end
          end
        end
        PLAY: begin
          if (w_player_strb) begin
            if (!is_letter(player_char) || ((r_guessed & w_letter_bit) != '0)) begin
              w_nxt_error = 1'b1;
            end else begin
              w_nxt_guessed = r_guessed | w_letter_bit;
              if (w_hit) begin
                w_nxt_mask = r_mask | w_match;
                if (&w_nxt_mask) w_nxt_state = WIN;
              end else begin
                w_nxt_mistakes = r_mistakes + 4'd1;
                if (w_nxt_mistakes == MISS_LIMIT) w_nxt_state = LOSE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= SETUP;
      r_idx      <= '0;
      r_mask     <= '0;
      r_mistakes <= '0;
      r_guessed  <= '0;
      r_error    <= 1'b0;
      r_msg_sent <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_red      <= 1'b0;
      r_green    <= 1'b0;
      r_blue     <= 1'b0;
      for (int unsigned i = 0; i < WORD_LEN; i++) r_word[i] <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_word     <= w_nxt_word;
      r_mask     <= w_nxt_mask;
      r_mistakes <= w_nxt_mistakes;
      r_guessed  <= w_nxt_guessed;
      r_error    <= w_nxt_error;
      r_msg_sent <= w_nxt_msg_sent;
      r_tx_valid <= w_nxt_tx_valid;
      r_tx_data  <= w_nxt_tx_data;
      r_red      <= (w_nxt_state == LOSE);
      r_green    <= (w_nxt_state == WIN);
      r_blue     <= (w_nxt_state == PLAY);
    end
  end

  assign tx.tx_valid = r_tx_valid;
  assign tx.tx_data  = r_tx_data;
  assign tx.msg_sent = r_msg_sent;
  assign reveal_mask = r_mask;
  assign mistakes    = r_mistakes;
  assign state       = r_state;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign error       = r_error;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Self-checking bench for hangman_game_ctrl against a game-rules reference model.
module tb_hangman_game_ctrl;
  import hangman_pkg::*;

  localparam int LEN  = 5;
  localparam int MAXM = 6;

  logic clk = 1'b0, nRst = 1'b0, role_switch = 1'b0;
  logic host_strb = 1'b0, host_word_submit = 1'b0, player_strb = 1'b0, restart = 1'b0;
  logic [7:0] host_char = '0, player_char = '0;
  logic [8*LEN-1:0] word_flat;
  logic [LEN-1:0]   reveal_mask;
  logic [3:0]       mistakes;
  state_t           state;
  logic             red, green, blue, error;

  hangman_game_ctrl_if tx_if ();

  hangman_game_ctrl #(.WORD_LEN(LEN), .MAX_MISTAKES(MAXM)) dut (
    .clk(clk), .nRst(nRst), .role_switch(role_switch),
    .host_strb(host_strb), .host_char(host_char), .host_word_submit(host_word_submit),
    .player_strb(player_strb), .player_char(player_char), .restart(restart),
    .tx(tx_if.master), .word_flat(word_flat), .reveal_mask(reveal_mask),
    .mistakes(mistakes), .state(state), .red(red), .green(green), .blue(blue), .error(error)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: the game as a player sees it
  logic [7:0]     m_word [LEN];
  int             m_entered;
  bit [25:0]      m_seen;
  logic [LEN-1:0] m_mask;
  int             m_miss;
  state_t         m_state;

  function automatic void m_clear();
    for (int i = 0; i < LEN; i++) m_word[i] = '0;
    m_entered = 0; m_seen = '0; m_mask = '0; m_miss = 0; m_state = SETUP;
  endfunction

  function automatic logic [8*LEN-1:0] m_flat();
    logic [8*LEN-1:0] f;
    f = '0;
    for (int i = 0; i < m_entered; i++) f[8*i +: 8] = m_word[i];
    return f;
  endfunction

  function automatic logic m_guess(input logic [7:0] c);
    bit hit;
    if (m_state != PLAY) return 1'b0;
    if (c < 8'h41 || c > 8'h5A) return 1'b1;
    if (m_seen[c - 8'h41]) return 1'b1;
    m_seen[c - 8'h41] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < LEN; i++) if (m_word[i] == c) begin m_mask[i] = 1'b1; hit = 1'b1; end
    if (!hit) m_miss++;
    if (m_mask == {LEN{1'b1}}) m_state = WIN;
    else if (m_miss == MAXM) m_state = LOSE;
    return 1'b0;
  endfunction

  task automatic pulse_host(input logic [7:0] c);
    @(negedge clk); host_strb = 1'b1; host_char = c;
    @(negedge clk); host_strb = 1'b0;
  endtask

  task automatic pulse_submit();
    @(negedge clk); host_word_submit = 1'b1;
    @(negedge clk); host_word_submit = 1'b0;
  endtask

  task automatic pulse_player(input logic [7:0] c);
    @(negedge clk); player_strb = 1'b1; player_char = c;
    @(negedge clk); player_strb = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    m_clear();
  endtask

  task automatic set_word(input string s);
    for (int i = 0; i < LEN; i++) m_word[i] = s[i];
  endtask

  // Enter m_word, submit, drain with tx_ready=1 and move the model to PLAY
  task automatic load_game();
    bit seen;
    role_switch = 1'b0;
    for (int i = 0; i < LEN; i++) pulse_host(m_word[i]);
    m_entered = LEN;
    pulse_submit();
    tx_if.tx_ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (tx_if.msg_sent === 1'b1) seen = 1'b1;
    end
    tx_if.tx_ready = 1'b0;
    nchk++;
    if (!seen) begin nerr++; $display("FAIL load_timeout: msg_sent=0 required=1 within 40 cycles"); end
    m_seen = '0; m_mask = '0; m_miss = 0; m_state = PLAY;
    role_switch = 1'b1;
  endtask

  task automatic test_reset();
    m_clear();
    #12;
    nchk++; if (state !== SETUP) begin nerr++; $display("FAIL reset_state: got %0d required %0d", state, SETUP); end
    nchk++; if ({tx_if.tx_valid, tx_if.tx_data, tx_if.msg_sent} !== 10'h0) begin nerr++;
      $display("FAIL reset_tx: got %h required 000", {tx_if.tx_valid, tx_if.tx_data, tx_if.msg_sent}); end
    nchk++; if (word_flat !== '0) begin nerr++; $display("FAIL reset_word: got %h required 0", word_flat); end
    nchk++; if ({reveal_mask, mistakes} !== '0) begin nerr++; $display("FAIL reset_score: got %h required 0", {reveal_mask, mistakes}); end
    nchk++; if ({red, green, blue, error} !== 4'b0) begin nerr++; $display("FAIL reset_flags: got %b required 0000", {red, green, blue, error}); end
    @(negedge clk); nRst = 1'b1;
  endtask

  task automatic test_setup_rules();
    logic [8*LEN-1:0] snap;
    role_switch = 1'b0;
    set_word("APPLE");
    for (int i = 0; i < 3; i++) begin
      pulse_host(m_word[i]); m_entered++;
      nchk++; if ({error, word_flat} !== {1'b0, m_flat()}) begin nerr++;
        $display("FAIL setup_letter%0d: got %h required %h", i, {error, word_flat}, {1'b0, m_flat()}); end
    end
    snap = m_flat();
    pulse_host(8'h31);
    nchk++; if ({error, word_flat} !== {1'b1, snap}) begin nerr++; $display("FAIL setup_digit: got %h required %h", {error, word_flat}, {1'b1, snap}); end
    @(negedge clk);
    nchk++; if (error !== 1'b0) begin nerr++; $display("FAIL error_one_cycle: got %b required 0", error); end
    pulse_host(8'h40);
    nchk++; if (error !== 1'b1) begin nerr++; $display("FAIL setup_below_A: got %b required 1", error); end
    pulse_host(8'h5B);
    nchk++; if (error !== 1'b1) begin nerr++; $display("FAIL setup_above_Z: got %b required 1", error); end
    pulse_submit();
    nchk++; if ({error, state} !== {1'b1, SETUP}) begin nerr++; $display("FAIL setup_early_submit: got %h required %h", {error, state}, {1'b1, SETUP}); end
    role_switch = 1'b1;
    pulse_host("Z");
    role_switch = 1'b0;
    nchk++; if ({error, word_flat} !== {1'b0, snap}) begin nerr++; $display("FAIL setup_role_ignore: got %h required %h", {error, word_flat}, {1'b0, snap}); end
    for (int i = 3; i < LEN; i++) begin pulse_host(m_word[i]); m_entered++; end
    nchk++; if ({state, word_flat} !== {READY, m_flat()}) begin nerr++;
      $display("FAIL setup_full: got %h required %h", {state, word_flat}, {READY, m_flat()}); end
    pulse_host("Q");
    nchk++; if ({error, state, word_flat} !== {1'b1, READY, m_flat()}) begin nerr++;
      $display("FAIL ready_strb: got %h required %h", {error, state, word_flat}, {1'b1, READY, m_flat()}); end
  endtask

  task automatic test_send();
    int  k, pulses;
    bit  r, done;
    k = 0; pulses = 0; done = 1'b0;
    pulse_submit();
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (k < LEN) begin
        nchk++;
        if ({tx_if.tx_valid, tx_if.tx_data, tx_if.msg_sent, state, error} !== {1'b1, m_word[k], 1'b0, SEND, 1'b0}) begin
          nerr++; $display("FAIL send_byte%0d: got %h required %h", k,
            {tx_if.tx_valid, tx_if.tx_data, tx_if.msg_sent, state, error}, {1'b1, m_word[k], 1'b0, SEND, 1'b0});
        end
        r = 1'($urandom_range(0, 1));
        tx_if.tx_ready = r;
        host_strb = 1'($urandom_range(0, 1));
        host_char = 8'h41 + 8'($urandom_range(0, 25));
        @(negedge clk);
        if (r) k++;
      end else begin
        done = 1'b1;
      end
    end
    tx_if.tx_ready = 1'b0; host_strb = 1'b0;
    nchk++;
    if ({done, tx_if.msg_sent, tx_if.tx_valid, state, blue} !== {1'b1, 1'b1, 1'b0, PLAY, 1'b1}) begin nerr++;
      $display("FAIL send_done: got %h required %h", {done, tx_if.msg_sent, tx_if.tx_valid, state, blue}, {1'b1, 1'b1, 1'b0, PLAY, 1'b1}); end
    if (tx_if.msg_sent === 1'b1) pulses++;
    @(negedge clk);
    if (tx_if.msg_sent === 1'b1) pulses++;
    nchk++; if (pulses != 1) begin nerr++; $display("FAIL msg_sent_pulse: got %0d pulses required 1", pulses); end
    m_seen = '0; m_mask = '0; m_miss = 0; m_state = PLAY;
  endtask

  task automatic test_play_win();
    string g;
    logic  e;
    logic [LEN-1:0] snap;
    g = "PPALE";
    role_switch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_player(g[i]);
      e = m_guess(g[i]);
      nchk++;
      if ({error, reveal_mask, mistakes, state, red, green, blue} !==
          {e, m_mask, 4'(m_miss), m_state, m_state == LOSE, m_state == WIN, m_state == PLAY}) begin
        nerr++; $display("FAIL win_guess%0d: got %h required %h", i, {error, reveal_mask, mistakes, state, red, green, blue},
          {e, m_mask, 4'(m_miss), m_state, m_state == LOSE, m_state == WIN, m_state == PLAY});
      end
      if (i == 0) begin
        nchk++; if (reveal_mask !== 5'b00110) begin nerr++; $display("FAIL guess_P_mask: got %b required 00110", reveal_mask); end
      end
    end
    snap = m_mask;
    for (int i = 0; i < 3; i++) begin
      pulse_player(8'h41 + 8'($urandom_range(0, 25)));
      nchk++;
      if ({error, reveal_mask, state, green} !== {1'b0, snap, WIN, 1'b1}) begin nerr++;
        $display("FAIL win_hold%0d: got %h required %h", i, {error, reveal_mask, state, green}, {1'b0, snap, WIN, 1'b1}); end
    end
  endtask

  task automatic test_lose();
    string g;
    logic  e;
    pulse_restart();
    set_word("MOORE");
    load_game();
    g = "BCDFGH";
    for (int i = 0; i < 6; i++) begin pulse_player(g[i]); e = m_guess(g[i]); end
    nchk++;
    if ({error, reveal_mask, mistakes, state, red, green, blue} !== {1'b0, 5'b0, 4'd6, LOSE, 1'b1, 1'b0, 1'b0}) begin nerr++;
      $display("FAIL lose_final: got %h required %h", {error, reveal_mask, mistakes, state, red, green, blue},
        {1'b0, 5'b0, 4'd6, LOSE, 1'b1, 1'b0, 1'b0}); end
    pulse_restart();
    nchk++;
    if ({state, word_flat, reveal_mask, mistakes, red, green, blue, error, tx_if.tx_valid} !== '0) begin nerr++;
      $display("FAIL lose_restart: got %h required 0", {state, word_flat, reveal_mask, mistakes, red, green, blue, error, tx_if.tx_valid}); end
  endtask

  task automatic test_restart_priority();
    set_word("ZEBRA");
    load_game();
    @(negedge clk); player_strb = 1'b1; player_char = "E"; restart = 1'b1;
    @(negedge clk); player_strb = 1'b0; restart = 1'b0;
    m_clear();
    nchk++;
    if ({state, error, reveal_mask, word_flat, blue} !== {SETUP, 1'b0, 5'b0, 40'h0, 1'b0}) begin nerr++;
      $display("FAIL restart_priority: got %h required %h", {state, error, reveal_mask, word_flat, blue}, {SETUP, 1'b0, 5'b0, 40'h0, 1'b0}); end
    role_switch = 1'b0;
    @(negedge clk); host_strb = 1'b1; host_char = "K"; restart = 1'b1;
    @(negedge clk); host_strb = 1'b0; restart = 1'b0;
    nchk++; if (word_flat !== '0) begin nerr++; $display("FAIL restart_over_host: got %h required 0", word_flat); end
  endtask

  task automatic test_random_games();
    logic [7:0] c;
    logic       e;
    int         sel;
    for (int gm = 0; gm < 6; gm++) begin
      pulse_restart();
      for (int i = 0; i < LEN; i++) m_word[i] = 8'h41 + 8'($urandom_range(0, 7));
      load_game();
      for (int n = 0; n < 80 && m_state == PLAY; n++) begin
        sel = $urandom_range(0, 11);
        if (sel < 8) c = 8'h41 + 8'(sel);
        else if (sel == 8) c = 8'h5A;
        else if (sel == 9) c = 8'h40;
        else if (sel == 10) c = 8'h5B;
        else c = 8'h49 + 8'($urandom_range(0, 3));
        pulse_player(c);
        e = m_guess(c);
        nchk++;
        if ({error, reveal_mask, mistakes, state, red, green, blue} !==
            {e, m_mask, 4'(m_miss), m_state, m_state == LOSE, m_state == WIN, m_state == PLAY}) begin
          nerr++; $display("FAIL rand_game%0d_guess%0d char=%h: got %h required %h", gm, n, c,
            {error, reveal_mask, mistakes, state, red, green, blue},
            {e, m_mask, 4'(m_miss), m_state, m_state == LOSE, m_state == WIN, m_state == PLAY});
        end
      end
      pulse_player("A");
      nchk++;
      if ({error, reveal_mask, mistakes, state} !== {1'b0, m_mask, 4'(m_miss), m_state}) begin nerr++;
        $display("FAIL rand_game%0d_end_hold: got %h required %h", gm, {error, reveal_mask, mistakes, state},
          {1'b0, m_mask, 4'(m_miss), m_state}); end
    end
  endtask

  task automatic test_reset_mid_send();
    pulse_restart();
    for (int i = 0; i < LEN; i++) m_word[i] = 8'h41 + 8'($urandom_range(0, 25));
    role_switch = 1'b0;
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < LEN; i++) pulse_host(m_word[i]);
    pulse_submit();
    repeat (3) @(negedge clk);
    nchk++;
    if ({tx_if.tx_valid, tx_if.tx_data, state} !== {1'b1, m_word[0], SEND}) begin nerr++;
      $display("FAIL stall_hold: got %h required %h", {tx_if.tx_valid, tx_if.tx_data, state}, {1'b1, m_word[0], SEND}); end
    #2 nRst = 1'b0;
    #1;
    nchk++;
    if ({state, tx_if.tx_valid, word_flat} !== {SETUP, 1'b0, 40'h0}) begin nerr++;
      $display("FAIL reset_mid_send: got %h required %h", {state, tx_if.tx_valid, word_flat}, {SETUP, 1'b0, 40'h0}); end
    @(negedge clk); nRst = 1'b1;
    @(negedge clk);
    m_clear();
    nchk++;
    if ({state, tx_if.tx_valid, tx_if.msg_sent, word_flat} !== {SETUP, 1'b0, 1'b0, 40'h0}) begin nerr++;
      $display("FAIL after_reset_release: got %h required %h", {state, tx_if.tx_valid, tx_if.msg_sent, word_flat},
        {SETUP, 1'b0, 1'b0, 40'h0}); end
  endtask

  initial begin
    tx_if.tx_ready = 1'b0;
    test_reset();
    test_setup_rules();
    test_send();
    test_play_win();
    test_lose();
    test_restart_priority();
    test_random_games();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1, "watchdog");
  end

endmodule
